// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: two-digit BCD run controller with prescaler, run FSM and one-shot/auto-reload terminal handling.
// Define BCD_TIMER_DOWN_EN to build down counting selected by iDown; otherwise the block counts up only.
module bcd_timer_ctrl #(
  parameter int PRESCALE = 4
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iStart,
  input  logic       iStop,
  input  logic       iClear,
  input  logic       iLoad,
  input  logic [3:0] iPreset1,
  input  logic [3:0] iPreset2,
  input  logic       iDown,
  input  logic       iAutoReload,
  output logic [3:0] oSalida1,
  output logic [3:0] oSalida2,
  output logic [1:0] oState,
  output logic       oBusy,
  output logic       oDone
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3;
  localparam logic [15:0] PMAX = 16'(PRESCALE - 1);
  logic [3:0] u_q, u_d, t_q, t_d, pu_q, pu_d, pt_q, pt_d, cu, ct, su, st;
  logic [15:0] pre_q, pre_d;
  logic [1:0] st_q, st_d;
  logic done_q, done_d, down, tick, term;
`ifdef BCD_TIMER_DOWN_EN
  assign down = iDown;
  assign su = down ? (u_q == 4'd0 ? 4'd9 : u_q - 4'd1) : (u_q == 4'd9 ? 4'd0 : u_q + 4'd1);
  assign st = down ? (u_q == 4'd0 ? t_q - 4'd1 : t_q) : (u_q == 4'd9 ? t_q + 4'd1 : t_q);
  assign term = down ? (u_q == 4'd0 && t_q == 4'd0) : (u_q == 4'd9 && t_q == 4'd9);
`else
  logic unused_down;
  assign unused_down = iDown;
  assign down = 1'b0;
  assign su = u_q == 4'd9 ? 4'd0 : u_q + 4'd1;
  assign st = u_q == 4'd9 ? t_q + 4'd1 : t_q;
  assign term = u_q == 4'd9 && t_q == 4'd9;
`endif
  assign cu = iPreset1 > 4'd9 ? 4'd9 : iPreset1;
  assign ct = iPreset2 > 4'd9 ? 4'd9 : iPreset2;
  assign tick = st_q == RUN && pre_q == PMAX;
  always_comb begin
    u_d = u_q;
    t_d = t_q;
    pu_d = pu_q;
    pt_d = pt_q;
    pre_d = pre_q;
    st_d = st_q;
    done_d = 1'b0;
    if (iClear) begin
      u_d = '0;
      t_d = '0;
      pre_d = '0;
      st_d = IDLE;
    end else if (iLoad && st_q != RUN) begin
      pu_d = cu;
      pt_d = ct;
      u_d = cu;
      t_d = ct;
      st_d = st_q == DONE ? IDLE : st_q;
    end else begin
      if (st_q == RUN) pre_d = tick ? '0 : pre_q + 16'd1;
      if (tick && term) begin
        done_d = 1'b1;
        u_d = iAutoReload ? pu_q : u_q;
        t_d = iAutoReload ? pt_q : t_q;
        st_d = iAutoReload ? RUN : DONE;
      end else if (tick) begin
        u_d = su;
        t_d = st;
      end
      // A one-shot terminal tick outranks a simultaneous stop.
      if (st_q == RUN && iStop && st_d == RUN) st_d = PAUSE;
      else if (st_q != RUN && iStart) begin
        st_d = RUN;
        pre_d = st_q == PAUSE ? pre_q : '0;
        u_d = st_q == DONE ? pu_q : u_q;
        t_d = st_q == DONE ? pt_q : t_q;
      end
    end
  end
  always_ff @(posedge iClk) begin
    if (iReset) begin
      u_q <= '0;
      t_q <= '0;
      pu_q <= '0;
      pt_q <= '0;
      pre_q <= '0;
      st_q <= IDLE;
      done_q <= 1'b0;
    end else begin
      u_q <= u_d;
      t_q <= t_d;
      pu_q <= pu_d;
      pt_q <= pt_d;
      pre_q <= pre_d;
      st_q <= st_d;
      done_q <= done_d;
    end
  end
  assign oSalida1 = u_q;
  assign oSalida2 = t_q;
  assign oState = st_q;
  assign oBusy = st_q == RUN;
  assign oDone = done_q;
endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb_bcd_timer_ctrl: directed and random stimulus against an integer-count reference model of bcd_timer_ctrl.
module tb_bcd_timer_ctrl;
  localparam int P = 4;
`ifdef BCD_TIMER_DOWN_EN
  localparam bit DEN = 1'b1;
`else
  localparam bit DEN = 1'b0;
`endif
  localparam int PASS = DEN ? 13 * P : 88 * P;
  logic iClk = 1'b0, iReset = 1'b0, iStart = 1'b0, iStop = 1'b0, iClear = 1'b0, iLoad = 1'b0;
  logic iDown = 1'b0, iAutoReload = 1'b0, oBusy, oDone;
  logic [3:0] iPreset1 = '0, iPreset2 = '0, oSalida1, oSalida2;
  logic [1:0] oState;
  int n_chk = 0, n_fail = 0;
  int m_st, m_cnt, m_pre, m_ph, m_done, dones;
  bcd_timer_ctrl #(.PRESCALE(P)) dut (
    .iClk(iClk), .iReset(iReset), .iStart(iStart), .iStop(iStop), .iClear(iClear),
    .iLoad(iLoad), .iPreset1(iPreset1), .iPreset2(iPreset2), .iDown(iDown),
    .iAutoReload(iAutoReload), .oSalida1(oSalida1), .oSalida2(oSalida2),
    .oState(oState), .oBusy(oBusy), .oDone(oDone)
  );
  always #5 iClk = ~iClk;
  function automatic int clamp(logic [3:0] v);
    return v > 4'd9 ? 9 : int'(v);
  endfunction
  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Count held as an integer 0..99; states IDLE=0 RUN=1 PAUSE=2 DONE=3; m_ph is clocks into the tick period.
  task automatic model();
    int s0;
    bit tk, dn;
    if (iReset) begin
      m_st = 0; m_cnt = 0; m_pre = 0; m_ph = 0; m_done = 0;
      return;
    end
    m_done = 0;
    s0 = m_st;
    if (iClear) begin
      m_cnt = 0; m_ph = 0; m_st = 0;
    end else if (iLoad && s0 != 1) begin
      m_pre = clamp(iPreset2) * 10 + clamp(iPreset1);
      m_cnt = m_pre;
      if (s0 == 3) m_st = 0;
    end else begin
      tk = s0 == 1 && m_ph == P - 1;
      if (s0 == 1) m_ph = tk ? 0 : m_ph + 1;
      if (tk) begin
        dn = DEN && iDown;
        if (m_cnt == (dn ? 0 : 99)) begin
          m_done = 1;
          if (iAutoReload) m_cnt = m_pre;
          else m_st = 3;
        end else m_cnt = m_cnt + (dn ? -1 : 1);
      end
      if (s0 == 1 && iStop && m_st == 1) m_st = 2;
      else if (s0 != 1 && iStart) begin
        if (s0 == 3) m_cnt = m_pre;
        if (s0 != 2) m_ph = 0;
        m_st = 1;
      end
    end
  endtask
  task automatic cyc();
    @(posedge iClk);
    model();
    #1;
    chk("units", 16'(oSalida1), 16'(m_cnt % 10));
    chk("tens", 16'(oSalida2), 16'(m_cnt / 10));
    chk("state", 16'(oState), 16'(m_st));
    chk("busy", 16'(oBusy), 16'(m_st == 1));
    chk("done", 16'(oDone), 16'(m_done));
    if (oDone === 1'b1) dones++;
  endtask
  initial begin
    iReset = 1'b1;
    cyc(); cyc();
    iReset = 1'b0;
    cyc();
    chk("rst_digits", {8'h0, oSalida2, oSalida1}, 16'h00);
    chk("rst_state", 16'(oState), 16'd0);
    iStart = 1'b1; cyc(); iStart = 1'b0;
    repeat (P) cyc();
    chk("first_tick", {8'h0, oSalida2, oSalida1}, 16'h01);
    repeat (9 * P) cyc();
    chk("ten_ticks", {8'h0, oSalida2, oSalida1}, 16'h10);
    chk("run_busy", 16'(oBusy), 16'd1);
    repeat (90 * P) cyc();
    chk("term_done", 16'(oDone), 16'd1);
    chk("term_state", 16'(oState), 16'd3);
    chk("term_digits", {8'h0, oSalida2, oSalida1}, 16'h99);
    cyc();
    chk("done_pulse", 16'(oDone), 16'd0);
    iStart = 1'b1; cyc(); iStart = 1'b0;
    chk("restart_state", 16'(oState), 16'd1);
    chk("restart_digits", {8'h0, oSalida2, oSalida1}, 16'h00);
    iClear = 1'b1; cyc(); iClear = 1'b0;
    iPreset1 = 4'd2; iPreset2 = 4'd1; iLoad = 1'b1; cyc(); iLoad = 1'b0;
    chk("load12", {8'h0, oSalida2, oSalida1}, 16'h12);
    iDown = 1'b1; iAutoReload = 1'b1; iStart = 1'b1; cyc(); iStart = 1'b0;
    dones = 0;
    repeat (PASS) cyc();
    chk("reload_digits", {8'h0, oSalida2, oSalida1}, 16'h12);
    chk("reload_pulses", 16'(dones), 16'd1);
    chk("reload_state", 16'(oState), 16'd1);
    iClear = 1'b1; cyc(); iClear = 1'b0;
    iPreset1 = 4'hC; iPreset2 = 4'hF; iLoad = 1'b1; cyc(); iLoad = 1'b0;
    chk("clamp", {8'h0, oSalida2, oSalida1}, 16'h99);
    iDown = 1'b0; iAutoReload = 1'b0;
    iClear = 1'b1; cyc(); iClear = 1'b0;
    iStart = 1'b1; cyc(); iStart = 1'b0;
    repeat (P + 1) cyc();
    iStop = 1'b1; cyc(); iStop = 1'b0;
    repeat (10) cyc();
    chk("pause_digits", {8'h0, oSalida2, oSalida1}, 16'h01);
    chk("pause_state", 16'(oState), 16'd2);
    iStart = 1'b1; cyc(); iStart = 1'b0;
    cyc();
    chk("resume_hold", {8'h0, oSalida2, oSalida1}, 16'h01);
    cyc();
    chk("resume_step", {8'h0, oSalida2, oSalida1}, 16'h02);
    iClear = 1'b1; cyc(); iClear = 1'b0;
    iPreset1 = 4'd9; iPreset2 = 4'd9; iLoad = 1'b1; cyc(); iLoad = 1'b0;
    iStart = 1'b1; cyc(); iStart = 1'b0;
    repeat (P - 1) cyc();
    iClear = 1'b1; iStart = 1'b1; cyc(); iClear = 1'b0; iStart = 1'b0;
    chk("clr_term_digits", {8'h0, oSalida2, oSalida1}, 16'h00);
    chk("clr_term_state", 16'(oState), 16'd0);
    chk("clr_term_done", 16'(oDone), 16'd0);
    iStart = 1'b1; cyc(); iStart = 1'b0;
    repeat (6) cyc();
    iReset = 1'b1; cyc(); iReset = 1'b0;
    chk("rst_run_state", 16'(oState), 16'd0);
    chk("rst_run_busy", 16'(oBusy), 16'd0);
    chk("rst_run_digits", {8'h0, oSalida2, oSalida1}, 16'h00);
    repeat (4000) begin
      iReset = $urandom_range(0, 999) < 3;
      iClear = $urandom_range(0, 99) < 2;
      iLoad = $urandom_range(0, 99) < 3;
      iStop = $urandom_range(0, 99) < 4;
      iStart = $urandom_range(0, 99) < 10;
      iPreset1 = 4'($urandom_range(0, 15));
      iPreset2 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) iDown = ~iDown;
      if ($urandom_range(0, 49) == 0) iAutoReload = ~iAutoReload;
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
